cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  32-bit bus-based CPU datapath: 16 GPRs, PC, IR, HI, LO, 64-bit Z, MAR, MDR, Y, C,
//  in/out port registers and a 32-bit ALU, all on one shared 32-bit bus.
//  Controlled cycle-by-cycle by external load (*in) / drive (*out) strobes
//  from the control unit or a bench. It sits between the control unit and memory;
//  memory data arrives on Mdatain.
// PARAMETERS
//  (none; data width fixed at 32, Z at 64)
// PORTS
//  Clock          in  1   single clock, all state updates on rising edge
//  Clear          in  1   synchronous active-high reset
//  R0in..R15in    in  1ea load GPR Rn from bus
//  PCin,IRin,HIin,LOin,MARin,Cin,Yin  in 1ea  load that register from bus
//  ZHighin        in  1   load Z[63:32] from ALU high result
//  ZLowin         in  1   load Z[31:0] from ALU low result
//  MDRin          in  1   load MDR from MDR input mux
//  OutPort        in  1   load out-port register from bus
//  R0out..R15out  in  1ea drive Rn onto bus
//  PCout,HIout,LOout,ZHighout,ZLowout,MDRout,MARout,Cout  in 1ea  drive register onto bus
//  InPort         in  1   drive in-port register onto bus
//  Read           in  1   MDR mux select: 1=Mdatain, 0=bus
//  Mdatain        in  32  memory read data
//  IncPC          in  1   increment PC
//  OP             in  5   ALU operation select
// BEHAVIOUR
//  - Reset: on posedge with Clear=1, every register (R0-R15, PC, IR, HI, LO, Z, MAR,
//    MDR, Y, C, in/out port) <= 0; Clear overrides all other strobes.
//  - Bus: combinational mux. If no *out asserted, bus = 0. Several *out asserted is
//    illegal; fixed priority R0>..>R15>PC>HI>LO>ZHigh>ZLow>InPort>MDR>MAR>C.
//  - Register loads: posedge, when its *in=1, value = bus (same-cycle out->in transfer).
//  - MDR: MDRin=1 loads (Read ? Mdatain : bus).
//  - PC: IncPC=1 -> PC <= PC+1 (priority); else PCin=1 -> PC <= bus. PCout with IncPC
//    in the same cycle drives the old PC.
//  - ALU combinational: A=Y, B=bus, result 64 bits {hi,lo}; non-MUL/DIV ops hi=0.
//    OP: 00011 ADD, 00100 SUB(A-B), 00101 AND, 00110 OR, 00111 SHR (logical),
//    01000 SHL, 01001 SHRA (arithmetic, sign of A), 01010 ROR, 01011 ROL,
//    01111 MUL (signed 32x32, hi:lo), 10000 DIV (signed, lo=quotient, hi=remainder),
//    10001 NEG (-B), 10010 NOT (~B); others -> 0.
//  - Shifts/rotates use B[4:0]; amount 0 returns A unchanged. ADD/SUB wrap mod 2^32.
//  - DIV by 0: lo=32'hFFFFFFFF, hi=A (no trap).
//  - Typical op: cycle1 Rx out+Yin; cycle2 Ry out, OP, ZLowin; cycle3 ZLowout, Rz in.
//  - Reg write visible on bus the cycle after the loading edge; no bypass.
// TESTING
//  - Reset: load R3=5 via MDR, then Clear=1 one edge -> every register reads 0 on bus.
//  - MDR path: Mdatain=FEDBCA98, Read+MDRin 1 edge, then MDRout+R3in -> R3=FEDBCA98.
//  - SHRA: R3=FEDBCA98, R5=0000000A; R3out+Yin; R5out,OP=01001,ZLowin; ZLowout+R1in
//    -> R1=FFFFB6F2.
//  - Fetch: PC=0; PCout+MARin+IncPC -> MAR=0, PC=1; Mdatain=409A8000 Read+MDRin;
//    MDRout+IRin -> IR=409A8000.
//  - MUL/DIV: Y=FFFFFFFE(-2), bus=3, OP=01111, ZHighin+ZLowin -> Z=FFFFFFFF_FFFFFFFA;
//    Y=7, bus=2, OP=10000 -> Z lo=3, hi=1.
//  - ROL wrap: Y=80000001, bus=1, OP=01011 -> Z lo=00000003; SHR by 0 -> Y unchanged.

Source files
------------

// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus CPU datapath.
//   16 GPRs, PC, IR, HI, LO, 64-bit Z, MAR, MDR, Y, C, in/out port registers
//   and a combinational ALU (A = Y, B = bus), all joined by one shared bus.
//   Every transfer is steered cycle-by-cycle by external strobes:
//     *in  : load register from bus (or ALU / MDR mux) on rising Clock edge
//     *out : drive register onto bus (fixed priority if several asserted)
// Ports:
//   Clock, Clear         clock, synchronous active-high reset
//   R0in..R15in, PCin, IRin, HIin, LOin, MARin, Cin, Yin, ZHighin, ZLowin,
//   MDRin, OutPort       load strobes
//   R0out..R15out, PCout, HIout, LOout, ZHighout, ZLowout, MDRout, MARout,
//   Cout, InPort         bus drive strobes
//   Read                 MDR source: 1 = Mdatain, 0 = bus
//   Mdatain [31:0]       memory read data
//   IncPC                PC <= PC + 1 (wins over PCin)
//   OP [4:0]             ALU operation
//   in_port_data [31:0]  external value sampled every cycle into the in-port register
//   bus [31:0]           current bus value
//   ir [31:0]            instruction register
//   out_port [31:0]      out-port register
module cpu_datapath (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        PCin, IRin, HIin, LOin, MARin, Cin, Yin,
  input  logic        ZHighin, ZLowin, MDRin, OutPort,
  input  logic        R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        PCout, HIout, LOout, ZHighout, ZLowout, MDRout, MARout, Cout,
  input  logic        InPort,
  input  logic        Read,
  input  logic [31:0] Mdatain,
  input  logic        IncPC,
  input  logic [4:0]  OP,
  input  logic [31:0] in_port_data,
  output logic [31:0] bus,
  output logic [31:0] ir,
  output logic [31:0] out_port
);

  localparam int NUM_GPR = 16;
  localparam int W       = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND = 5'b00101, OP_OR  = 5'b00110,
    OP_SHR  = 5'b00111, OP_SHL  = 5'b01000, OP_SHRA = 5'b01001, OP_ROR = 5'b01010,
    OP_ROL  = 5'b01011, OP_MUL  = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [NUM_GPR-1:0]        r_in, r_out;
  logic [NUM_GPR-1:0][W-1:0] gpr_q;
  logic [W-1:0] pc, hi_q, lo_q, mar_q, mdr_q, y_q, c_q, in_q, mdr_d;
  logic [2*W-1:0] z_q, alu;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // ---------------------------------------------------------------- registers
  dp_reg32 u_gpr [NUM_GPR-1:0] (.Clock(Clock), .Clear(Clear), .ld(r_in), .d(bus), .q(gpr_q));

  assign mdr_d = Read ? Mdatain : bus;

  dp_reg32 u_ir   (.Clock(Clock), .Clear(Clear), .ld(IRin),    .d(bus),          .q(ir));
  dp_reg32 u_hi   (.Clock(Clock), .Clear(Clear), .ld(HIin),    .d(bus),          .q(hi_q));
  dp_reg32 u_lo   (.Clock(Clock), .Clear(Clear), .ld(LOin),    .d(bus),          .q(lo_q));
  dp_reg32 u_mar  (.Clock(Clock), .Clear(Clear), .ld(MARin),   .d(bus),          .q(mar_q));
  dp_reg32 u_mdr  (.Clock(Clock), .Clear(Clear), .ld(MDRin),   .d(mdr_d),        .q(mdr_q));
  dp_reg32 u_y    (.Clock(Clock), .Clear(Clear), .ld(Yin),     .d(bus),          .q(y_q));
  dp_reg32 u_c    (.Clock(Clock), .Clear(Clear), .ld(Cin),     .d(bus),          .q(c_q));
  dp_reg32 u_oprt (.Clock(Clock), .Clear(Clear), .ld(OutPort), .d(bus),          .q(out_port));
  // in-port register simply tracks the external pins, one cycle delayed
  dp_reg32 u_iprt (.Clock(Clock), .Clear(Clear), .ld(1'b1),    .d(in_port_data), .q(in_q));

  // PC: increment beats a bus load; PCout in the same cycle still sees old PC
  always_ff @(posedge Clock) begin
    if (Clear)      pc <= '0;
    else if (IncPC) pc <= pc + 32'd1;
    else if (PCin)  pc <= bus;
  end

  // Z halves load independently from the matching ALU result half
  always_ff @(posedge Clock) begin
    if (Clear) begin
      z_q <= '0;
    end else begin
      if (ZHighin) z_q[63:32] <= alu[63:32];
      if (ZLowin)  z_q[31:0]  <= alu[31:0];
    end
  end

  // ---------------------------------------------------------------- bus mux
  // GPRs scanned high-to-low so the lowest-numbered asserted one wins.
  always_comb begin
    bus = '0;
    if (|r_out) begin
      for (int i = NUM_GPR - 1; i >= 0; i--)
        if (r_out[i[3:0]]) bus = gpr_q[i[3:0]];
    end
    else if (PCout)    bus = pc;
    else if (HIout)    bus = hi_q;
    else if (LOout)    bus = lo_q;
    else if (ZHighout) bus = z_q[63:32];
    else if (ZLowout)  bus = z_q[31:0];
    else if (InPort)   bus = in_q;
    else if (MDRout)   bus = mdr_q;
    else if (MARout)   bus = mar_q;
    else if (Cout)     bus = c_q;
  end

  // ---------------------------------------------------------------- ALU
  logic [W-1:0]          a, b;
  logic [4:0]            sh;
  logic signed [2*W-1:0] a64, b64, mul_p;
  logic [W-1:0]          a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign a  = y_q;
  assign b  = bus;
  assign sh = b[4:0];

  assign a64   = {{W{a[W-1]}}, a};
  assign b64   = {{W{b[W-1]}}, b};
  assign mul_p = a64 * b64;

  // Signed divide through magnitudes: truncates toward zero, remainder takes
  // the dividend's sign, and MIN/-1 wraps to MIN without any special case.
  assign a_mag = a[W-1] ? (~a + 32'd1) : a;
  assign b_mag = b[W-1] ? (~b + 32'd1) : b;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quo   = (a[W-1] ^ b[W-1]) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a[W-1] ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    alu = '0;
    case (OP)
      OP_ADD:  alu[31:0] = a + b;
      OP_SUB:  alu[31:0] = a - b;
      OP_AND:  alu[31:0] = a & b;
      OP_OR:   alu[31:0] = a | b;
      OP_SHR:  alu[31:0] = a >> sh;
      OP_SHL:  alu[31:0] = a << sh;
      OP_SHRA: alu[31:0] = $signed(a) >>> sh;
      OP_ROR:  alu[31:0] = (sh == 5'd0) ? a : ((a >> sh) | (a << (6'd32 - {1'b0, sh})));
      OP_ROL:  alu[31:0] = (sh == 5'd0) ? a : ((a << sh) | (a >> (6'd32 - {1'b0, sh})));
      OP_MUL:  alu       = mul_p;
      OP_DIV:  alu       = (b == '0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
      OP_NEG:  alu[31:0] = 32'd0 - b;
      OP_NOT:  alu[31:0] = ~b;
      default: alu       = '0;
    endcase
  end

endmodule

// dp_reg32: 32-bit load-enabled register with synchronous clear.
//   Clock, Clear : clock / synchronous active-high clear (wins over ld)
//   ld, d, q     : load enable, next value, current value
module dp_reg32 (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge Clock) begin
    if (Clear)   q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed + randomized bench for cpu_datapath. Expected ALU results come
// from a plain-arithmetic reference function; GPR contents are tracked in a
// bench-side array as values are moved through the datapath.
module tb_cpu_datapath;

  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Clear;
  logic [15:0] rin, rout;
  logic        PCin, IRin, HIin, LOin, MARin, Cin, Yin, ZHighin, ZLowin, MDRin, OutPort;
  logic        PCout, HIout, LOout, ZHighout, ZLowout, MDRout, MARout, Cout, InPort;
  logic        Read, IncPC;
  logic [31:0] Mdatain, in_port_data;
  logic [4:0]  OP;
  logic [31:0] bus, ir, out_port;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_r [16];

  cpu_datapath dut (
    .Clock(Clock), .Clear(Clear),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .MARin(MARin), .Cin(Cin), .Yin(Yin),
    .ZHighin(ZHighin), .ZLowin(ZLowin), .MDRin(MDRin), .OutPort(OutPort),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .MDRout(MDRout), .MARout(MARout), .Cout(Cout), .InPort(InPort),
    .Read(Read), .Mdatain(Mdatain), .IncPC(IncPC), .OP(OP),
    .in_port_data(in_port_data), .bus(bus), .ir(ir), .out_port(out_port)
  );

  // Reference ALU: straight from the operation definitions.
  function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    int unsigned n;
    longint sa, sb, p, q, r;
    logic [63:0] aa;
    n  = b[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    aa = {a, a};
    case (op)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  return {32'h0, a >> n};
      5'd8:  return {32'h0, a << n};
      5'd9:  begin p = sa >>> n; return {32'h0, p[31:0]}; end
      5'd10: begin aa = aa >> n; return {32'h0, aa[31:0]}; end
      5'd11: begin aa = aa << n; return {32'h0, aa[63:32]}; end
      5'd15: begin p = sa * sb; return p; end
      5'd16: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      5'd17: return {32'h0, 32'h0 - b};
      5'd18: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic idle();
    rin = '0; rout = '0;
    {PCin, IRin, HIin, LOin, MARin, Cin, Yin, ZHighin, ZLowin, MDRin, OutPort} = '0;
    {PCout, HIout, LOout, ZHighout, ZLowout, MDRout, MARout, Cout, InPort} = '0;
    Read = 1'b0; IncPC = 1'b0; OP = 5'd0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // compare the bus against exp with whatever out strobe the caller raised
  task automatic peek(input string tag, input logic [31:0] exp);
    #1;
    check(tag, bus, exp);
    idle();
  endtask

  task automatic rd_gpr(input int i, output logic [31:0] v);
    rout[i] = 1'b1;
    #1;
    v = bus;
    rout[i] = 1'b0;
  endtask

  task automatic load_reg(input int i, input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick(); idle();
    MDRout = 1'b1; rin[i] = 1'b1;
    tick(); idle();
    m_r[i] = v;
  endtask

  // Rx -> Y; Ry + OP -> Z; Z lo -> Rz. Returns the observed {Zhi, Zlo}.
  task automatic alu_run(input int x, input int y, input logic [4:0] op, input int z,
                         output logic [63:0] zr);
    rout[x] = 1'b1; Yin = 1'b1;
    tick(); idle();
    rout[y] = 1'b1; OP = op; ZHighin = 1'b1; ZLowin = 1'b1;
    tick(); idle();
    ZHighout = 1'b1;
    #1 zr[63:32] = bus;
    idle();
    ZLowout = 1'b1; rin[z] = 1'b1;
    #1 zr[31:0] = bus;
    tick(); idle();
  endtask

  logic [31:0] v;
  logic [63:0] zr, ze;
  logic [4:0]  ops [16] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                            5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd12, 5'd31};

  initial begin
    idle();
    Mdatain = '0; in_port_data = '0;
    Clear = 1'b1;
    tick(); tick();
    Clear = 1'b0;

    // ---- reset: dirty several registers, then clear with strobes still active
    load_reg(3, 32'd5);
    rd_gpr(3, v); check("r3_pre_reset", v, 32'd5);
    rout[3] = 1'b1; {PCin, IRin, HIin, LOin, MARin, Cin, Yin, OutPort} = '1;
    OP = 5'd3; ZHighin = 1'b1; ZLowin = 1'b1; rin[4] = 1'b1;
    tick(); idle();
    rout[3] = 1'b1; rin[7] = 1'b1; MDRin = 1'b1; Clear = 1'b1;
    tick(); idle(); Clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_gpr(i, v); check($sformatf("rst_r%0d", i), v, 32'h0); m_r[i] = '0;
    end
    PCout = 1'b1;    peek("rst_pc", 32'h0);
    HIout = 1'b1;    peek("rst_hi", 32'h0);
    LOout = 1'b1;    peek("rst_lo", 32'h0);
    ZHighout = 1'b1; peek("rst_zhi", 32'h0);
    ZLowout = 1'b1;  peek("rst_zlo", 32'h0);
    InPort = 1'b1;   peek("rst_inport", 32'h0);
    MDRout = 1'b1;   peek("rst_mdr", 32'h0);
    MARout = 1'b1;   peek("rst_mar", 32'h0);
    Cout = 1'b1;     peek("rst_c", 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_outport", out_port, 32'h0);
    peek("bus_idle", 32'h0);

    // ---- fetch: PCout drives old PC while IncPC bumps it
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
    #1 check("fetch_bus_old_pc", bus, 32'h0);
    tick(); idle();
    MARout = 1'b1; peek("fetch_mar", 32'h0);
    PCout = 1'b1;  peek("fetch_pc", 32'h1);
    Mdatain = 32'h409A_8000; Read = 1'b1; MDRin = 1'b1;
    tick(); idle();
    MDRout = 1'b1; IRin = 1'b1;
    tick(); idle();
    check("fetch_ir", ir, 32'h409A_8000);

    // ---- MDR path, and no bypass before the loading edge
    Mdatain = 32'hFEDB_CA98; Read = 1'b1; MDRin = 1'b1;
    tick(); idle();
    MDRout = 1'b1; rin[3] = 1'b1; rout[3] = 1'b1;
    #1 check("mdr_no_bypass", bus, 32'h0);
    rout[3] = 1'b0;
    tick(); idle();
    m_r[3] = 32'hFEDB_CA98;
    rd_gpr(3, v); check("mdr_r3", v, 32'hFEDB_CA98);

    // ---- PC: IncPC wins over PCin; plain PCin loads bus
    rout[3] = 1'b1; PCin = 1'b1; IncPC = 1'b1;
    tick(); idle();
    PCout = 1'b1; peek("pc_inc_prio", 32'h2);
    rout[3] = 1'b1; PCin = 1'b1;
    tick(); idle();
    PCout = 1'b1; peek("pc_load", 32'hFEDB_CA98);

    // ---- HI / LO / C / MAR / out-port / in-port
    rout[3] = 1'b1; HIin = 1'b1; LOin = 1'b1; Cin = 1'b1; OutPort = 1'b1;
    tick(); idle();
    HIout = 1'b1; peek("hi_load", 32'hFEDB_CA98);
    LOout = 1'b1; peek("lo_load", 32'hFEDB_CA98);
    Cout = 1'b1;  peek("c_load", 32'hFEDB_CA98);
    check("outport_load", out_port, 32'hFEDB_CA98);
    in_port_data = 32'h1357_9BDF;
    tick();
    InPort = 1'b1; peek("inport", 32'h1357_9BDF);

    // ---- bus priority with two GPR drivers
    load_reg(2, 32'h2222_2222);
    load_reg(7, 32'h7777_7777);
    rout[2] = 1'b1; rout[7] = 1'b1; peek("bus_prio_r2", 32'h2222_2222);
    rout[7] = 1'b1; PCout = 1'b1;   peek("bus_prio_r7_pc", 32'h7777_7777);

    // ---- SHRA example
    load_reg(5, 32'h0000_000A);
    alu_run(3, 5, 5'b01001, 1, zr);
    m_r[1] = zr[31:0];
    rd_gpr(1, v); check("shra_r1", v, 32'hFFFF_B6F2);
    check("shra_zhi", zr[63:32], 32'h0);

    // ---- MUL / DIV examples
    load_reg(8, 32'hFFFF_FFFE);
    load_reg(9, 32'h3);
    alu_run(8, 9, 5'b01111, 10, zr);
    check("mul_hi", zr[63:32], 32'hFFFF_FFFF);
    check("mul_lo", zr[31:0],  32'hFFFF_FFFA);
    m_r[10] = zr[31:0];
    load_reg(8, 32'h7);
    load_reg(9, 32'h2);
    alu_run(8, 9, 5'b10000, 10, zr);
    check("div_q", zr[31:0],  32'h3);
    check("div_r", zr[63:32], 32'h1);
    m_r[10] = zr[31:0];
    load_reg(9, 32'h0);
    alu_run(8, 9, 5'b10000, 10, zr);
    check("div0_lo", zr[31:0],  32'hFFFF_FFFF);
    check("div0_hi", zr[63:32], 32'h7);
    m_r[10] = zr[31:0];

    // ---- ROL wrap, SHR by zero
    load_reg(11, 32'h8000_0001);
    load_reg(12, 32'h1);
    alu_run(11, 12, 5'b01011, 13, zr);
    check("rol_wrap", zr[31:0], 32'h0000_0003);
    m_r[13] = zr[31:0];
    alu_run(3, 9, 5'b00111, 13, zr);
    check("shr_zero", zr[31:0], 32'hFEDB_CA98);
    m_r[13] = zr[31:0];

    // ---- randomized ALU traffic against the reference model
    for (int k = 0; k < 40; k++) begin
      int x, y, z;
      logic [31:0] a, b;
      logic [4:0] op;
      x  = $urandom_range(0, 15);
      y  = (x + 1 + $urandom_range(0, 14)) % 16;
      z  = $urandom_range(0, 15);
      op = ops[$urandom_range(0, 15)];
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      load_reg(x, a);
      load_reg(y, b);
      alu_run(x, y, op, z, zr);
      ze = alu_ref(m_r[x], m_r[y], op);
      check($sformatf("rnd%0d_op%0d_hi", k, op), zr[63:32], ze[63:32]);
      check($sformatf("rnd%0d_op%0d_lo", k, op), zr[31:0],  ze[31:0]);
      m_r[z] = ze[31:0];
      rd_gpr(z, v);
      check($sformatf("rnd%0d_rz", k), v, m_r[z]);
    end

    // ---- final sweep: every GPR still matches the tracked contents
    for (int i = 0; i < 16; i++) begin
      rd_gpr(i, v); check($sformatf("final_r%0d", i), v, m_r[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
